// File: rtl/axi_line_refill_master.sv
// axi_line_refill_master: turns one cache line-miss request into a single
// AXI4 burst read of a full line and streams the beats back as indexed words.
//
// Optional feature macro: REFILL_CRITICAL_WORD_FIRST_EN
//   defined   -> word-aligned araddr, WRAP burst, fill index starts at the missed word
//   undefined -> line-aligned araddr, INCR burst, fill index starts at 0
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   miss_req_i / miss_addr_i        line-fill request and missing byte address
//   miss_gnt_o                      request accepted (high while idle)
//   fill_valid_o/data/word/last/err indexed word return to the line buffer
//   busy_o                          refill in progress
//   m_axi_ar*                       AXI4 read address channel
//   m_axi_r*                        AXI4 read data channel
module axi_line_refill_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          miss_req_i,
  input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
  output logic                          miss_gnt_o,
  output logic                          fill_valid_o,
  output logic [DATA_WIDTH-1:0]         fill_data_o,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word_o,
  output logic                          fill_last_o,
  output logic                          fill_err_o,
  output logic                          busy_o,
  output logic [ID_WIDTH-1:0]           m_axi_arid,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int unsigned IDX_W      = $clog2(LINE_WORDS);
  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);
  localparam logic [1:0]            BURST     = 2'b10;
`else
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [1:0]            BURST     = 2'b01;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]        word_q, word_d;
  logic [IDX_W-1:0]        beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    drain_q, drain_d;
  logic                    fill_valid_q, fill_valid_d;
  logic [DATA_WIDTH-1:0]   fill_data_q, fill_data_d;
  logic [IDX_W-1:0]        fill_word_q, fill_word_d;
  logic                    fill_last_q, fill_last_d;
  logic                    fill_err_q, fill_err_d;
  logic [IDX_W-1:0]        start_word_c;
  logic                    count_end_c, line_end_c, beat_err_c;
  logic                    unused_rresp_lsb;

  // Only the error bit of rresp matters; OKAY vs EXOKAY is irrelevant here.
  assign unused_rresp_lsb = m_axi_rresp[0];

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  assign start_word_c = miss_addr_i[IDX_W+1:2];
`else
  assign start_word_c = '0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      word_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      drain_q      <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_data_q  <= '0;
      fill_word_q  <= '0;
      fill_last_q  <= 1'b0;
      fill_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      drain_q      <= drain_d;
      fill_valid_q <= fill_valid_d;
      fill_data_q  <= fill_data_d;
      fill_word_q  <= fill_word_d;
      fill_last_q  <= fill_last_d;
      fill_err_q   <= fill_err_d;
    end
  end

  // Next-state and fill generation
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_d       = word_q;
    beat_d       = beat_q;
    err_d        = err_q;
    drain_d      = drain_q;
    fill_valid_d = 1'b0;
    fill_data_d  = fill_data_q;
    fill_word_d  = fill_word_q;
    fill_last_d  = 1'b0;
    fill_err_d   = 1'b0;
    count_end_c  = 1'b0;
    line_end_c   = 1'b0;
    beat_err_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_req_i) begin
          addr_d  = miss_addr_i & ADDR_MASK;
          word_d  = start_word_c;
          beat_d  = '0;
          err_d   = 1'b0;
          drain_d = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi_arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (m_axi_rvalid) begin
          if (drain_q) begin
            // Surplus beats after a count-forced line end are swallowed.
            if (m_axi_rlast) begin
              drain_d = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            count_end_c  = (beat_q == LAST_BEAT);
            line_end_c   = m_axi_rlast | count_end_c;
            // Error: bad response, early rlast, or missing rlast on the final beat.
            beat_err_c   = m_axi_rresp[1] | (m_axi_rlast ^ count_end_c);
            fill_valid_d = 1'b1;
            fill_data_d  = m_axi_rdata;
            fill_word_d  = word_q;
            fill_last_d  = line_end_c;
            fill_err_d   = line_end_c & (err_q | beat_err_c);
            word_d       = word_q + IDX_W'(1);
            beat_d       = beat_q + IDX_W'(1);
            err_d        = err_q | beat_err_c;
            if (line_end_c) begin
              err_d = 1'b0;
              if (m_axi_rlast) state_d = S_IDLE;
              else             drain_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign miss_gnt_o    = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign m_axi_arvalid = (state_q == S_ADDR);
  assign m_axi_rready  = (state_q == S_DATA);
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = BURST;

  assign fill_valid_o  = fill_valid_q;
  assign fill_data_o   = fill_data_q;
  assign fill_word_o   = fill_word_q;
  assign fill_last_o   = fill_last_q;
  assign fill_err_o    = fill_err_q;

endmodule

// File: tb/tb_axi_line_refill_master.sv
// Directed bench for axi_line_refill_master (LINE_WORDS = 4) with an in-bench
// AXI slave and a queue of expected fill words.
module tb_axi_line_refill_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_req_i;
  logic [31:0] miss_addr_i;
  logic        miss_gnt_o;
  logic        fill_valid_o;
  logic [31:0] fill_data_o;
  logic [1:0]  fill_word_o;
  logic        fill_last_o;
  logic        fill_err_o;
  logic        busy_o;
  logic [3:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  axi_line_refill_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .ID_WIDTH(4), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i), .miss_gnt_o(miss_gnt_o),
    .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o), .fill_word_o(fill_word_o),
    .fill_last_o(fill_last_o), .fill_err_o(fill_err_o), .busy_o(busy_o),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  w;
    logic        l;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] req_addr;
  logic [31:0] slave_addr;
  logic [1:0]  slave_burst;

  function automatic logic [31:0] mem_word(input logic [31:0] widx);
    case (widx)
      32'd128: return 32'hfe010113;
      32'd129: return 32'h00112e23;
      32'd130: return 32'h00812c23;
      32'd131: return 32'h02010413;
      default: return {widx[15:0], ~widx[15:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and score any fill word the DUT emitted.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (fill_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fill", 64'(fill_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("fill_data", 64'(fill_data_o), 64'(e.d));
        chk("fill_word", 64'(fill_word_o), 64'(e.w));
        chk("fill_last", 64'(fill_last_o), 64'(e.l));
        if (e.l) chk("fill_err", 64'(fill_err_o), 64'(e.e));
      end
    end
  endtask

  task automatic request(input logic [31:0] a);
    req_addr    = a;
    miss_addr_i = a;
    miss_req_i  = 1'b1;
    chk("gnt_idle", 64'(miss_gnt_o), 64'd1);
    tick();
    miss_req_i  = 1'b0;
    chk("busy_after_req", 64'(busy_o), 64'd1);
  endtask

  task automatic ar_phase(input int stall);
    logic [31:0] exp_addr;
    logic [1:0]  exp_burst;
    int n;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    exp_addr  = req_addr & ~32'h3;
    exp_burst = 2'b10;
`else
    exp_addr  = req_addr & ~32'hF;
    exp_burst = 2'b01;
`endif
    n = 0;
    while (m_axi_arvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("arvalid", 64'(m_axi_arvalid), 64'd1);
    chk("araddr", 64'(m_axi_araddr), 64'(exp_addr));
    chk("arlen", 64'(m_axi_arlen), 64'd3);
    chk("arsize", 64'(m_axi_arsize), 64'd2);
    chk("arburst", 64'(m_axi_arburst), 64'(exp_burst));
    chk("arid", 64'(m_axi_arid), 64'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
      chk("ar_hold_addr", 64'(m_axi_araddr), 64'(exp_addr));
      chk("ar_hold_len", 64'(m_axi_arlen), 64'd3);
    end
    slave_addr    = m_axi_araddr;
    slave_burst   = m_axi_arburst;
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    chk("ar_single", 64'(m_axi_arvalid), 64'd0);
  endtask

  // Slave returns beat k; optionally queue the fill the cache should see.
  task automatic beat(input int k, input logic [1:0] resp, input logic last,
                      input logic exp_fill, input logic exp_last, input logic exp_err);
    logic [31:0] ba;
    logic [1:0]  wi;
    logic [1:0]  idx;
    exp_t        e;
    if (slave_burst == 2'b10) begin
      wi = slave_addr[3:2] + 2'(k);
      ba = {slave_addr[31:4], wi, 2'b00};
    end else begin
      ba = slave_addr + 32'(4 * k);
    end
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    idx = req_addr[3:2] + 2'(k);
`else
    idx = 2'(k);
`endif
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = mem_word(ba >> 2);
    m_axi_rresp  = resp;
    m_axi_rlast  = last;
    chk("rready", 64'(m_axi_rready), 64'd1);
    if (exp_fill) begin
      e.d = mem_word(({req_addr[31:4], 4'b0000} >> 2) + 32'(idx));
      e.w = idx;
      e.l = exp_last;
      e.e = exp_err;
      exp_q.push_back(e);
    end
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rresp  = 2'b00;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic full_line(input logic [31:0] a, input int stall);
    request(a);
    ar_phase(stall);
    beat(0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(2, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(3, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("gnt_after_line", 64'(miss_gnt_o), 64'd1);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n         = 1'b1;
    miss_req_i    = 1'b0;
    miss_addr_i   = '0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
    req_addr      = '0;
    slave_addr    = '0;
    slave_burst   = 2'b00;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 64'(miss_gnt_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    chk("rst_fill_valid", 64'(fill_valid_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic line, with a second request held while busy.
    request(32'h0000_0208);
    ar_phase(0);
    beat(0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    miss_addr_i = 32'h0000_0F00;
    miss_req_i  = 1'b1;
    chk("gnt_while_busy", 64'(miss_gnt_o), 64'd0);
    beat(1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(2, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(3, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("gnt_after_last", 64'(miss_gnt_o), 64'd1);
    miss_req_i = 1'b0;
    chk("sb_empty_basic", 64'(exp_q.size()), 64'd0);
    tick();
    chk("idle_busy", 64'(busy_o), 64'd0);

    // AR stalled for five cycles.
    full_line(32'h0000_1014, 5);
    tick();

    // SLVERR on beat 1: all words delivered, error on the last.
    request(32'h0000_020C);
    ar_phase(0);
    beat(0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(2, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(3, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("sb_empty_resp", 64'(exp_q.size()), 64'd0);
    tick();

    // Early rlast on beat 2.
    request(32'h0000_0300);
    ar_phase(1);
    beat(0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(2, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("early_idle", 64'(busy_o), 64'd0);
    chk("sb_empty_early", 64'(exp_q.size()), 64'd0);
    tick();

    // Missing rlast: count ends the line, surplus beats drained silently.
    request(32'h0000_0404);
    ar_phase(0);
    beat(0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(2, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("drain_busy", 64'(busy_o), 64'd1);
    beat(4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_busy2", 64'(busy_o), 64'd1);
    beat(5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("drain_done", 64'(miss_gnt_o), 64'd1);
    chk("sb_empty_drain", 64'(exp_q.size()), 64'd0);
    tick();

    // Reset during beat 2, then a clean line.
    request(32'h0000_0500);
    ar_phase(0);
    beat(0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    beat(1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = 32'hdead_beef;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 64'(miss_gnt_o), 64'd1);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_rready", 64'(m_axi_rready), 64'd0);
    chk("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("midrst_fill_valid", 64'(fill_valid_o), 64'd0);
    chk("midrst_fill_last", 64'(fill_last_o), 64'd0);
    m_axi_rvalid = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    full_line(32'h0000_0208, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
